// File: rtl/ej32_au_sched.sv
// ---------------------------------------------------------------------------
// ej32_au_sched -- scheduler for the extended arithmetic unit.
//
// Accepts one request at a time from two requesters and returns one tagged
// result for each request. Port 0 is the core execute stage and port 1 is a
// secondary master. When both ports request in the same cycle, a round-robin
// pointer picks the winner.
//
// Multiply and shift ops are computed combinationally on accept and returned
// one cycle later. Divide and remainder ops go through the external iterative
// divider using its reset/busy handshake. A timeout guards against a divider
// that never finishes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_vld / reqN_rdy      request handshake for port N (rdy is combinational)
//   reqN_op                  0 mul, 1 div, 2 rem, 3 shl, 4 shr, 5 ushr, 6-7 illegal
//   reqN_s / reqN_t          NOS / TOS operands
//   rsp_vld / rsp_rdy        response handshake
//   rsp_id                   port that owns the response
//   rsp_v / rsp_err          result value / error flag (div by 0, timeout, illegal)
//   div_rst                  divider hold/clear; the divider runs while this is low
//   div_x / div_y            registered dividend / divisor
//   div_bsy, div_q, div_r    divider busy, quotient, remainder
//   au_bsy                   high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module ej32_au_sched #(
  parameter int DSZ     = 32,
  parameter int DIV_TMO = 48
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_vld,
  output logic           req0_rdy,
  input  logic [2:0]     req0_op,
  input  logic [DSZ-1:0] req0_s,
  input  logic [DSZ-1:0] req0_t,
  input  logic           req1_vld,
  output logic           req1_rdy,
  input  logic [2:0]     req1_op,
  input  logic [DSZ-1:0] req1_s,
  input  logic [DSZ-1:0] req1_t,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic           rsp_id,
  output logic [DSZ-1:0] rsp_v,
  output logic           rsp_err,
  output logic           div_rst,
  output logic [DSZ-1:0] div_x,
  output logic [DSZ-1:0] div_y,
  input  logic           div_bsy,
  input  logic [DSZ-1:0] div_q,
  input  logic [DSZ-1:0] div_r,
  output logic           au_bsy
);

  localparam int SHW = $clog2(DSZ);
  localparam int CW  = $clog2(DIV_TMO + 1);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_REM  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_USHR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    DIV_ARM,
    DIV_RUN,
    RESP
  } state_t;

  state_t state_q, state_d;

  // Round-robin pointer: 0 favours port 0 on a tie, 1 favours port 1.
  logic           rr_q;
  logic           grant0, grant1;
  logic           accept, sel;
  logic [2:0]     a_op;
  logic [DSZ-1:0] a_s, a_t;
  logic           a_is_div, a_div_start, a_illegal;
  logic [DSZ-1:0] comb_res;

  logic           id_q;
  logic           is_rem_q;
  logic           seen_bsy_q;
  logic [CW-1:0]  run_cnt_q;
  logic [DSZ-1:0] rsp_v_q, div_x_q, div_y_q;
  logic           rsp_err_q;
  logic           div_done, div_tmo;

  // -------------------------------------------------------------------------
  // Arbitration. Grants are only offered in IDLE; the reset term keeps both
  // ready lines low while reset is asserted even though the state is IDLE.
  // -------------------------------------------------------------------------
  assign grant0   = req0_vld && (!req1_vld || !rr_q);
  assign grant1   = req1_vld && (!req0_vld ||  rr_q);
  assign req0_rdy = !rst && (state_q == IDLE) && grant0;
  assign req1_rdy = !rst && (state_q == IDLE) && grant1;

  // A ready line is only ever high together with its valid, so either ready
  // being high means a request is accepted this cycle.
  assign accept = req0_rdy || req1_rdy;
  assign sel    = req1_rdy;

  assign a_op        = sel ? req1_op : req0_op;
  assign a_s         = sel ? req1_s  : req0_s;
  assign a_t         = sel ? req1_t  : req0_t;
  assign a_is_div    = (a_op == OP_DIV) || (a_op == OP_REM);
  assign a_div_start = a_is_div && (a_t != '0);
  assign a_illegal   = (a_op > OP_USHR);

  // Single-cycle ops. The low DSZ bits of a product are the same for signed
  // and unsigned operands, so a plain DSZ-wide multiply gives the signed result.
  // NOTE: every signal written in an always_comb gets a default first so that
  //       no path leaves it unassigned, which would infer a latch.
  always_comb begin
    comb_res = '0;
    case (a_op)
      OP_MUL:  comb_res = a_s * a_t;
      OP_SHL:  comb_res = a_s << a_t[SHW-1:0];
      OP_SHR:  comb_res = $signed(a_s) >>> a_t[SHW-1:0];
      OP_USHR: comb_res = a_s >> a_t[SHW-1:0];
      default: comb_res = '0;
    endcase
  end

  // The divider is finished once it has been seen busy and has then dropped
  // busy again; a divider that has not yet raised busy is still starting up.
  assign div_done = seen_bsy_q && !div_bsy;
  assign div_tmo  = (run_cnt_q == CW'(DIV_TMO - 1));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = a_div_start ? DIV_ARM : RESP;
      end
      DIV_ARM: state_d = DIV_RUN;
      DIV_RUN: begin
        if (div_done || div_tmo) state_d = RESP;
      end
      RESP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  //       flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      is_rem_q   <= 1'b0;
      seen_bsy_q <= 1'b0;
      run_cnt_q  <= '0;
      rsp_v_q    <= '0;
      rsp_err_q  <= 1'b0;
      div_x_q    <= '0;
      div_y_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q     <= sel;
            rr_q     <= !sel;
            is_rem_q <= (a_op == OP_REM);
            if (a_div_start) begin
              div_x_q <= a_s;
              div_y_q <= a_t;
            end else begin
              // Divide by zero and illegal ops both answer 0 with an error.
              rsp_v_q   <= (a_is_div || a_illegal) ? '0 : comb_res;
              rsp_err_q <= a_is_div || a_illegal;
            end
          end
        end
        DIV_ARM: begin
          seen_bsy_q <= 1'b0;
          run_cnt_q  <= '0;
        end
        DIV_RUN: begin
          if (div_bsy) seen_bsy_q <= 1'b1;
          run_cnt_q <= run_cnt_q + CW'(1);
          // A completion on the last allowed cycle wins over the timeout.
          if (div_done) begin
            rsp_v_q   <= is_rem_q ? div_r : div_q;
            rsp_err_q <= 1'b0;
          end else if (div_tmo) begin
            rsp_v_q   <= '0;
            rsp_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_vld = (state_q == RESP);
  assign rsp_id  = id_q;
  assign rsp_v   = rsp_v_q;
  assign rsp_err = rsp_err_q;
  assign div_rst = (state_q != DIV_RUN);
  assign div_x   = div_x_q;
  assign div_y   = div_y_q;
  assign au_bsy  = (state_q != IDLE);

endmodule

// File: tb/tb_ej32_au_sched.sv
// ---------------------------------------------------------------------------
// Testbench for ej32_au_sched: directed cases with literal expectations,
// then randomized traffic from both ports checked every cycle against a
// transaction-level model (expected-response queue plus grant prediction).
// A simple clocked divider model sits on the divider interface.
// ---------------------------------------------------------------------------
module tb_ej32_au_sched;

  localparam int DSZ     = 32;
  localparam int DIV_TMO = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_vld, req0_rdy, req1_vld, req1_rdy;
  logic [2:0]      req0_op, req1_op;
  logic [DSZ-1:0]  req0_s, req0_t, req1_s, req1_t;
  logic            rsp_vld, rsp_rdy, rsp_id, rsp_err;
  logic [DSZ-1:0]  rsp_v;
  logic            div_rst, div_bsy, au_bsy;
  logic [DSZ-1:0]  div_x, div_y, div_q, div_r;

  always #5 clk = ~clk;

  ej32_au_sched #(.DSZ(DSZ), .DIV_TMO(DIV_TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0_vld(req0_vld),
    .req0_rdy(req0_rdy),
    .req0_op (req0_op),
    .req0_s  (req0_s),
    .req0_t  (req0_t),
    .req1_vld(req1_vld),
    .req1_rdy(req1_rdy),
    .req1_op (req1_op),
    .req1_s  (req1_s),
    .req1_t  (req1_t),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_id  (rsp_id),
    .rsp_v   (rsp_v),
    .rsp_err (rsp_err),
    .div_rst (div_rst),
    .div_x   (div_x),
    .div_y   (div_y),
    .div_bsy (div_bsy),
    .div_q   (div_q),
    .div_r   (div_r),
    .au_bsy  (au_bsy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Divider model: idle while div_rst is high; once released it raises busy
  // after a short random delay, stays busy for a random number of cycles and
  // then presents the signed quotient and remainder. dm_stuck keeps it busy.
  // -------------------------------------------------------------------------
  bit       dm_stuck = 1'b0;
  logic [7:0] dm_cnt;
  int       dm_dly, dm_len;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_bsy <= 1'b0;
      div_q   <= '0;
      div_r   <= '0;
      dm_cnt  <= '0;
      dm_dly  <= 0;
      dm_len  <= 1;
    end else if (div_rst) begin
      div_bsy <= 1'b0;
      dm_cnt  <= '0;
      dm_dly  <= $urandom_range(0, 2);
      dm_len  <= $urandom_range(1, 12);
    end else begin
      dm_cnt <= dm_cnt + 8'd1;
      if (div_bsy) begin
        div_q <= $urandom;
        div_r <= $urandom;
      end
      if (dm_stuck) div_bsy <= 1'b1;
      else if (int'(dm_cnt) == dm_dly) div_bsy <= 1'b1;
      else if (int'(dm_cnt) == dm_dly + dm_len) begin
        div_bsy <= 1'b0;
        div_q   <= 32'(longint'($signed(div_x)) / longint'($signed(div_y)));
        div_r   <= 32'(longint'($signed(div_x)) % longint'($signed(div_y)));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: what each accepted request must answer.
  // -------------------------------------------------------------------------
  typedef struct {
    bit          id;
    logic [31:0] v;
    bit          err;
    bit          real_div;
    bit          tmo;
    logic [31:0] s;
    logic [31:0] t;
  } exp_t;

  function automatic exp_t model_op(input bit id, input logic [2:0] op,
                                    input logic [31:0] s, input logic [31:0] t,
                                    input bit stuck);
    exp_t e;
    longint ls = longint'($signed(s));
    longint lt = longint'($signed(t));
    logic signed [31:0] ss = s;
    e.id = id; e.v = '0; e.err = 1'b0; e.real_div = 1'b0; e.tmo = 1'b0;
    e.s = s; e.t = t;
    case (op)
      3'd0: e.v = 32'(ls * lt);
      3'd1, 3'd2: begin
        if (t == 32'd0) e.err = 1'b1;
        else begin
          e.real_div = 1'b1;
          if (stuck) begin e.err = 1'b1; e.tmo = 1'b1; end
          else e.v = (op == 3'd1) ? 32'(ls / lt) : 32'(ls % lt);
        end
      end
      3'd3: e.v = s << t[4:0];
      3'd4: e.v = ss >>> t[4:0];
      3'd5: e.v = s >> t[4:0];
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  exp_t exp_q[$];
  bit   m_busy = 1'b0;
  bit   m_rr   = 1'b0;
  int   m_cyc, run_cnt, n_rsp = 0;
  bit   seen_rsp;
  bit   was_busy, acc0, acc1;
  exp_t cur;

  // One compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_req0_rdy", req0_rdy, 0);
      check("rst_req1_rdy", req1_rdy, 0);
      check("rst_rsp_vld", rsp_vld, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_v", rsp_v, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_div_rst", div_rst, 1);
      check("rst_div_x", div_x, 0);
      check("rst_div_y", div_y, 0);
      check("rst_au_bsy", au_bsy, 0);
      exp_q.delete();
      m_busy = 1'b0;
      m_rr   = 1'b0;
    end else begin
      was_busy = m_busy;
      check("grant0", req0_rdy, !m_busy && req0_vld && (!req1_vld || !m_rr));
      check("grant1", req1_rdy, !m_busy && req1_vld && (!req0_vld || m_rr));
      check("au_bsy", au_bsy, m_busy);
      if (!m_busy) begin
        check("idle_rsp_vld", rsp_vld, 0);
        check("idle_div_rst", div_rst, 1);
      end else begin
        m_cyc++;
        cur = exp_q[0];
        if (cur.real_div) begin
          if (m_cyc == 1) begin
            check("arm_div_rst", div_rst, 1);
            check("arm_rsp_vld", rsp_vld, 0);
          end
          if (m_cyc == 2) begin
            check("run_div_rst", div_rst, 0);
            check("run_rsp_vld", rsp_vld, 0);
          end
          if (!rsp_vld) begin
            if (!div_rst) run_cnt++;
            check("div_x", div_x, cur.s);
            check("div_y", div_y, cur.t);
          end else begin
            check("resp_div_rst", div_rst, 1);
            if (!seen_rsp) begin
              if (cur.tmo) check("tmo_cycles", run_cnt, DIV_TMO);
              else         check("run_within_tmo", 32'(run_cnt <= DIV_TMO), 1);
            end
          end
        end else begin
          check("nodiv_div_rst", div_rst, 1);
          if (m_cyc == 1) check("lat1_rsp_vld", rsp_vld, 1);
        end
        if (rsp_vld) begin
          seen_rsp = 1'b1;
          check("rsp_id", rsp_id, cur.id);
          check("rsp_v", rsp_v, cur.v);
          check("rsp_err", rsp_err, cur.err);
          if (rsp_rdy) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            n_rsp++;
          end
        end
      end
      acc0 = req0_vld && req0_rdy;
      acc1 = req1_vld && req1_rdy;
      if (!was_busy && (acc0 || acc1)) begin
        if (acc1) exp_q.push_back(model_op(1'b1, req1_op, req1_s, req1_t, dm_stuck));
        else      exp_q.push_back(model_op(1'b0, req0_op, req0_s, req0_t, dm_stuck));
        m_rr     = !acc1;
        m_busy   = 1'b1;
        m_cyc    = 0;
        run_cnt  = 0;
        seen_rsp = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // -------------------------------------------------------------------------
  task automatic drive(input int p, input bit v, input logic [2:0] op,
                       input logic [31:0] s, input logic [31:0] t);
    if (p == 0) begin req0_vld = v; req0_op = op; req0_s = s; req0_t = t; end
    else        begin req1_vld = v; req1_op = op; req1_s = s; req1_t = t; end
  endtask

  task automatic start_req(input int p, input logic [2:0] op,
                           input logic [31:0] s, input logic [31:0] t);
    @(posedge clk); #1;
    drive(p, 1'b1, op, s, t);
  endtask

  task automatic wait_acc(input int p, input string name);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = (p == 0) ? (req0_vld && req0_rdy) : (req1_vld && req1_rdy);
      n++;
    end
    if (!got) check({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    if (p == 0) req0_vld = 1'b0;
    else        req1_vld = 1'b0;
  endtask

  task automatic send(input int p, input logic [2:0] op,
                      input logic [31:0] s, input logic [31:0] t, input string name);
    start_req(p, op, s, t);
    wait_acc(p, name);
  endtask

  // Waits for rsp_vld and checks it against literals; exp_lat = 0 means the
  // response must already be valid on the cycle right after accept.
  task automatic get_rsp(input string name, input bit id, input logic [31:0] v,
                         input bit err, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_vld) check({name, "_rsp_timeout"}, 0, 1);
    else begin
      check({name, "_id"}, rsp_id, id);
      check({name, "_v"}, rsp_v, v);
      check({name, "_err"}, rsp_err, err);
      if (exp_lat >= 0) check({name, "_lat"}, n, exp_lat);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (au_bsy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (au_bsy) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic rand_req(input int p);
    int r = $urandom_range(0, 15);
    logic [2:0]  op = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
    logic [31:0] s = $urandom;
    logic [31:0] t = $urandom;
    if (op == 3'd1 || op == 3'd2) begin
      case ($urandom_range(0, 7))
        0: t = 32'd0;
        1: begin s = 32'h8000_0000; t = 32'hFFFF_FFFF; end
        2, 3: t = 32'($urandom_range(1, 20));
        default: ;
      endcase
    end
    drive(p, 1'b1, op, s, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    bit a0, a1;
    int cyc, last, k;
    bit id;

    rst = 1'b1;
    rsp_rdy = 1'b1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Both ports hold shl requests: grants alternate starting with port 0.
    drive(0, 1'b1, 3'd3, 32'd1, 32'd1);
    drive(1, 1'b1, 3'd3, 32'd1, 32'd2);
    cyc = 0; last = 0; k = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if ((req0_vld && req0_rdy) || (req1_vld && req1_rdy)) begin
        id = req1_vld && req1_rdy;
        check("arb_order", id, 32'(k % 2));
        if (k > 0) check("arb_gap", cyc - last, 2);
        last = cyc;
        k++;
      end
    end
    if (k < 4) check("arb_grant_count", k, 4);
    @(posedge clk); #1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    wait_idle("arb");

    // Single-cycle ops and the divider path.
    send(0, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    get_rsp("mul", 1'b0, 32'hFFFF_FFEB, 1'b0, 0);
    send(1, 3'd1, 32'd100, 32'd7, "div");
    get_rsp("div", 1'b1, 32'd14, 1'b0, -1);
    send(1, 3'd2, 32'd100, 32'd7, "rem");
    get_rsp("rem", 1'b1, 32'd2, 1'b0, -1);
    send(1, 3'd4, 32'h8000_0000, 32'd4, "shr");
    get_rsp("shr", 1'b1, 32'hF800_0000, 1'b0, 0);
    send(1, 3'd5, 32'h8000_0000, 32'd4, "ushr");
    get_rsp("ushr", 1'b1, 32'h0800_0000, 1'b0, 0);

    // Error cases.
    send(0, 3'd1, 32'd5, 32'd0, "divz");
    get_rsp("divz", 1'b0, 32'd0, 1'b1, 0);
    send(0, 3'd7, 32'd5, 32'd3, "illegal");
    get_rsp("illegal", 1'b0, 32'd0, 1'b1, 0);
    dm_stuck = 1'b1;
    send(0, 3'd1, 32'd100, 32'd7, "tmo");
    get_rsp("tmo", 1'b0, 32'd0, 1'b1, -1);
    wait_idle("tmo");
    dm_stuck = 1'b0;

    // Response back-pressure: everything holds, no grants while stalled.
    @(posedge clk); #1 rsp_rdy = 1'b0;
    send(0, 3'd0, 32'd3, 32'd5, "stall");
    start_req(1, 3'd3, 32'd1, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld", rsp_vld, 1);
      check("stall_v", rsp_v, 32'd15);
      check("stall_err", rsp_err, 0);
      check("stall_id", rsp_id, 0);
      check("stall_rdy0", req0_rdy, 0);
      check("stall_rdy1", req1_rdy, 0);
      check("stall_au_bsy", au_bsy, 1);
    end
    @(posedge clk); #1 rsp_rdy = 1'b1;
    wait_acc(1, "after_stall");
    get_rsp("after_stall", 1'b1, 32'd8, 1'b0, 0);
    wait_idle("after_stall");

    // Asynchronous reset while the divider is running.
    send(1, 3'd1, 32'd100, 32'd7, "rst_div");
    k = 0;
    @(negedge clk);
    while (div_rst && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("reached_div_run", div_rst, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("async_div_rst", div_rst, 1);
    check("async_rsp_vld", rsp_vld, 0);
    check("async_au_bsy", au_bsy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    send(0, 3'd0, 32'd7, 32'hFFFF_FFFD, "post_rst");
    get_rsp("post_rst", 1'b0, 32'hFFFF_FFEB, 1'b0, 0);
    wait_idle("post_rst");

    // Randomized traffic; the compare process checks every cycle.
    k = n_rsp;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      a0 = req0_vld && req0_rdy;
      a1 = req1_vld && req1_rdy;
      @(posedge clk); #1;
      if (a0) req0_vld = 1'b0;
      if (a1) req1_vld = 1'b0;
      if (!req0_vld && $urandom_range(0, 2) == 0) rand_req(0);
      if (!req1_vld && $urandom_range(0, 2) == 0) rand_req(1);
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    rsp_rdy  = 1'b1;
    wait_idle("random");
    check("random_rsp_count_ok", 32'((n_rsp - k) > 200), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ej32_au_sched.md
Name: ej32_au_sched

Overview:
- Scheduler for the extended arithmetic unit (multiplier, shifters, iterative integer divider).
- Arbitrates two requesters: port 0 is the core execute stage, port 1 is a secondary master such as a debug or co-processor port.
- Sequences the multi-cycle divider through its reset/busy protocol and returns one tagged result per request over a valid/ready response port.
- Only one operation is in flight at a time.

Parameters:
- DSZ, 32: operand and result width.
- DIV_TMO, 48: cycle limit in DIV_RUN before the divide is aborted with an error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req0_vld  in  1  request valid, port 0.
- req0_rdy  out  1  request accepted, port 0.
- req0_op  in  3  op code: 0 mul, 1 div, 2 rem, 3 shl, 4 shr, 5 ushr, 6-7 illegal.
- req0_s  in  DSZ  NOS operand (dividend / value shifted).
- req0_t  in  DSZ  TOS operand (multiplier / divisor / shift count).
- req1_vld, req1_rdy, req1_op, req1_s, req1_t: same as port 0, for port 1.
- rsp_vld  out  1  result valid.
- rsp_rdy  in  1  result consumed.
- rsp_id  out  1  requester that owns the result.
- rsp_v  out  DSZ  result value.
- rsp_err  out  1  divide-by-zero, timeout, or illegal op.
- div_rst  out  1  divider hold/clear; the divider runs while this is low.
- div_x  out  DSZ  dividend to divider (registered).
- div_y  out  DSZ  divisor to divider (registered).
- div_bsy  in  1  divider busy.
- div_q  in  DSZ  divider quotient.
- div_r  in  DSZ  divider remainder.
- au_bsy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - req0_rdy = req1_rdy = 0.
  - rsp_vld = 0, rsp_id = 0, rsp_v = 0, rsp_err = 0.
  - div_rst = 1, div_x = div_y = 0.
  - au_bsy = 0, state = IDLE, RR pointer = 0 (port 0 favoured).
- FSM states: IDLE, DIV_ARM, DIV_RUN, RESP.
- Arbitration (IDLE only):
  - reqN_rdy is combinational, high only for the granted port, and only in IDLE.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port indicated by the RR pointer. After every grant the pointer points to the other port.
  - A request is accepted on the cycle where vld and rdy are both high. Operands, op and id are latched on that cycle.
- Combinational ops, on accept:
  - mul: low DSZ bits of the signed product s*t.
  - shl: s << t[4:0].
  - shr: arithmetic s >> t[4:0].
  - ushr: logical s >> t[4:0].
  - Result is registered. Go to RESP; rsp_vld is high the cycle after accept (latency 1).
- Illegal op (6-7): go to RESP with rsp_v = 0 and rsp_err = 1; latency 1.
- div/rem, t == 0:
  - Divider is not started; div_rst stays high.
  - Go to RESP with rsp_v = 0 and rsp_err = 1; latency 1.
- div/rem, t != 0:
  - Latch div_x = s and div_y = t, then go to DIV_ARM.
  - DIV_ARM: div_rst = 1 for exactly one cycle, then go to DIV_RUN.
  - DIV_RUN: div_rst = 0; an internal seen_bsy flag is set when div_bsy = 1.
  - Completion is the first cycle with seen_bsy && !div_bsy. Capture div_q (div) or div_r (rem) into rsp_v with rsp_err = 0, go to RESP, and drive div_rst = 1 from the next cycle.
  - A cycle counter clears on entry to DIV_RUN. If it reaches DIV_TMO, abort: rsp_v = 0, rsp_err = 1, go to RESP, div_rst = 1.
  - Signed overflow (MIN / -1) returns whatever the divider produces, unmodified.
- RESP:
  - rsp_vld = 1; rsp_v, rsp_err and rsp_id are held stable until rsp_rdy.
  - On rsp_vld && rsp_rdy, go to IDLE.
  - No new request is granted on that same cycle; the earliest next accept is the following cycle, so throughput is at most one op per 2 cycles.
- Ordering: responses are returned in accept order, trivially, because only one op is in flight.
- div_rst is high in every state except DIV_RUN.
- Async reset mid-operation (any state): all outputs immediately return to their reset values. Any in-flight result is discarded; no response is issued for it.
- A requester holding vld while not granted must keep its op and operands stable. The block does not check this.

Test Plan:
- Port 0: mul, s = 7, t = 0xFFFFFFFD (-3) -> rsp_vld on the cycle after accept; rsp_v = 0xFFFFFFEB, rsp_err = 0, rsp_id = 0.
- Port 1: div, s = 100, t = 7 -> div_rst pulses for one cycle, then the divider runs; rsp_v = 14, rsp_id = 1. Repeat with rem -> rsp_v = 2. Then shr, s = 0x80000000, t = 4 -> 0xF8000000; ushr with the same operands -> 0x08000000.
- div, s = 5, t = 0 -> div_rst never drops; rsp_v = 0, rsp_err = 1, latency 1. Also: op = 7 -> rsp_err = 1. Also: divider model with div_bsy stuck high -> rsp_err = 1 exactly after DIV_TMO cycles in DIV_RUN.
- Both ports hold vld with shl ops, rsp_rdy tied high -> grants go 0,1,0,1, one accept every 2 cycles, and each rsp_id matches its grant.
- rsp_rdy held low for 5 cycles after rsp_vld -> rsp_v, rsp_err and rsp_id stay stable, req0_rdy and req1_rdy stay low, au_bsy = 1.
- Assert rst asynchronously during DIV_RUN -> in the same cycle div_rst = 1, rsp_vld = 0, au_bsy = 0; after release a new mul completes normally and no stale response appears.
